// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered 8N1 UART transmitter, one byte queued per rising edge of send_flag.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits (8E1).
module uart_transmitter #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] in,
    input  logic       send_flag,
    output logic       UART_TX,
    output logic       busy,
    output logic       fifo_full,
    output logic       tx_done,
    output logic       overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic             send_prev;
    logic             armed;
    logic             push;
    logic             push_ok;
    logic             pop;

    // armed stays low until send_flag is seen low, so a level held through reset is not an edge
    assign push      = send_flag & ~send_prev & armed;
    assign fifo_full = (occupancy == OCC_FULL);
    assign push_ok   = push & ~fifo_full;
    assign pop       = (state == IDLE) && (occupancy != '0);
    assign busy      = (state != IDLE) || (occupancy != '0);

    always_ff @(posedge CLOCK_50) begin
        if (push_ok)
            mem[wr_ptr] <= in;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            send_prev <= 1'b0;
            armed     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            send_prev <= send_flag;
            armed     <= armed | ~send_flag;
            if (push & fifo_full)
                overflow <= 1'b1;
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // UART_TX is registered from the current state, so the line trails the state by one cycle
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            UART_TX   <= 1'b1;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    UART_TX  <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        state <= START;
                    end
                end
                START: begin
                    UART_TX <= 1'b0;
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    UART_TX <= shift_reg[0];
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    UART_TX <= parity_bit;
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    UART_TX <= 1'b1;
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    UART_TX  <= 1'b1;
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench; a line monitor decodes frames and checks them against queued bytes.
// Build with UART_TX_PARITY_EN to exercise the 8E1 variant.
module tb_uart_transmitter;

    localparam int C = 50000000 / 115200;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       CLOCK_50;
    logic       reset_n;
    logic [7:0] in;
    logic       send_flag;
    logic       UART_TX;
    logic       busy;
    logic       fifo_full;
    logic       tx_done;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rx_count    = 0;
    int done_cnt    = 0;
    int low_cycles  = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_transmitter dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .in       (in),
        .send_flag(send_flag),
        .UART_TX  (UART_TX),
        .busy     (busy),
        .fifo_full(fifo_full),
        .tx_done  (tx_done),
        .overflow (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc++;

    always @(negedge CLOCK_50) begin
        if (tx_done === 1'b1) done_cnt++;
        if (reset_n === 1'b1 && UART_TX === 1'b0) low_cycles++;
    end

    // Line monitor: frames are sampled every cycle, so any bit that is short or long breaks its window
    initial begin
        logic       bits [0:10];
        int         frame_start;
        bit         aborted;
        bit         glitch;
        logic       done_last;
        logic [7:0] data;
        logic [7:0] exp_b;
        forever begin
            @(negedge CLOCK_50);
            if (reset_n === 1'b1 && UART_TX === 1'b0) begin
                frame_start = cyc;
                aborted     = 1'b0;
                glitch      = 1'b0;
                done_last   = 1'b0;
                for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
                    for (int k = 0; k < C && !aborted; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge CLOCK_50);
                        if (reset_n !== 1'b1) aborted = 1'b1;
                        if (k == 0) bits[b] = UART_TX;
                        else if (UART_TX !== bits[b]) glitch = 1'b1;
                        if (b == FRAME_BITS - 1 && k == C - 1) done_last = tx_done;
                    end
                end
                if (!aborted) begin
                    rx_count++;
                    start_q.push_back(frame_start);
                    for (int i = 0; i < 8; i++) data[i] = bits[i + 1];
                    exp_b = 8'hxx;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL unexpected_frame: got %h, none queued", data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (data !== exp_b) begin
                            miscompares++;
                            $display("[TB] FAIL frame_data: got %h expected %h", data, exp_b);
                        end
                    end
                    vectors++;
                    if (glitch || bits[0] !== 1'b0 || bits[FRAME_BITS - 1] !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL frame_format: glitch=%0d start=%b stop=%b expected glitch=0 start=0 stop=1",
                                 glitch, bits[0], bits[FRAME_BITS - 1]);
                    end
`ifdef UART_TX_PARITY_EN
                    vectors++;
                    if (bits[9] !== ^exp_b) begin
                        miscompares++;
                        $display("[TB] FAIL parity_bit: got %b expected %b", bits[9], ^exp_b);
                    end
`endif
                    vectors++;
                    if (done_last !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL tx_done_at_stop_end: got %b expected 1", done_last);
                    end
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge CLOCK_50);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic [7:0] b, output int drive_cyc);
        @(negedge CLOCK_50);
        in        = b;
        send_flag = 1'b1;
        drive_cyc = cyc;
        @(negedge CLOCK_50);
        send_flag = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_idle_timeout: busy=%b expected 0 within %0d cycles", name, busy, budget);
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        reset_n   = 1'b0;
        send_flag = 1'b0;
        in        = 8'h00;
        exp_q.delete();
        repeat (3) @(negedge CLOCK_50);
        vectors += 5;
        if (UART_TX !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx: got %b expected 1", UART_TX); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (fifo_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", fifo_full); end
        if (tx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done); end
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        reset_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic test_single();
        int d;
        int base_rx   = rx_count;
        int base_done = done_cnt;
        start_q.delete();
        exp_q.push_back(8'h55);
        apply_stimulus(8'h55, d);
        wait_idle(FRAME_BITS * C + 100, "single");
        vectors += 4;
        if (rx_count - base_rx != 1) begin
            miscompares++; $display("[TB] FAIL single_frames: got %0d expected 1", rx_count - base_rx);
        end
        if (start_q.size() < 1 || start_q[0] != d + 3) begin
            miscompares++;
            $display("[TB] FAIL single_latency: got start %0d expected %0d", (start_q.size() > 0) ? start_q[0] : -1, d + 3);
        end
        if (done_cnt - base_done != 1) begin
            miscompares++; $display("[TB] FAIL single_tx_done_count: got %0d expected 1", done_cnt - base_done);
        end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        int d;
        int base_rx   = rx_count;
        int base_done = done_cnt;
        exp_q.push_back(8'h10);
        apply_stimulus(8'h10, d);
        repeat (3) @(negedge CLOCK_50);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            apply_stimulus(8'(i), d);
        end
        vectors++;
        if (fifo_full !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_full_seen: got %b expected 1", fifo_full); end
        apply_stimulus(8'h05, d);
        vectors += 2;
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_set: got %b expected 1", overflow); end
        if (fifo_full !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_full_hold: got %b expected 1", fifo_full); end
        wait_idle(5 * (FRAME_BITS * C + 1) + 200, "overflow");
        vectors += 4;
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow); end
        if (rx_count - base_rx != 5) begin
            miscompares++; $display("[TB] FAIL overflow_frames: got %0d expected 5", rx_count - base_rx);
        end
        if (exp_q.size() != 0) begin
            miscompares++; $display("[TB] FAIL overflow_pending: got %0d expected 0", exp_q.size());
        end
        if (done_cnt - base_done != 5) begin
            miscompares++; $display("[TB] FAIL overflow_tx_done_count: got %0d expected 5", done_cnt - base_done);
        end
    endtask

    task automatic test_hold();
        int base_rx = rx_count;
        @(negedge CLOCK_50);
        exp_q.push_back(8'hA3);
        in        = 8'hA3;
        send_flag = 1'b1;
        repeat (10000) @(negedge CLOCK_50);
        send_flag = 1'b0;
        wait_idle(FRAME_BITS * C + 100, "hold");
        vectors += 3;
        if (rx_count - base_rx != 1) begin
            miscompares++; $display("[TB] FAIL hold_frames: got %0d expected 1", rx_count - base_rx);
        end
        if (exp_q.size() != 0) begin
            miscompares++; $display("[TB] FAIL hold_pending: got %0d expected 0", exp_q.size());
        end
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_midframe();
        int d;
        int fs;
        int base_rx;
        int base_done;
        int base_low;
        exp_q.delete();
        apply_stimulus(8'hFF, d);
        fs = d + 3;
        apply_stimulus(8'h11, d);
        apply_stimulus(8'h22, d);
        while (cyc < fs + 4 * C + C / 2) @(negedge CLOCK_50);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL midframe_busy_before: got %b expected 1", busy); end
        base_rx   = rx_count;
        base_done = done_cnt;
        base_low  = low_cycles;
        @(negedge CLOCK_50);
        reset_n   = 1'b0;
        send_flag = 1'b1;
        #1;
        vectors += 5;
        if (UART_TX !== 1'b1) begin miscompares++; $display("[TB] FAIL midframe_tx: got %b expected 1", UART_TX); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_busy: got %b expected 0", busy); end
        if (fifo_full !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_full: got %b expected 0", fifo_full); end
        if (tx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_done: got %b expected 0", tx_done); end
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_overflow: got %b expected 0", overflow); end
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (1000) @(negedge CLOCK_50);
        vectors += 4;
        if (low_cycles != base_low) begin
            miscompares++; $display("[TB] FAIL midframe_line_quiet: got %0d low cycles expected 0", low_cycles - base_low);
        end
        if (rx_count != base_rx) begin
            miscompares++; $display("[TB] FAIL midframe_frames: got %0d expected 0", rx_count - base_rx);
        end
        if (done_cnt != base_done) begin
            miscompares++; $display("[TB] FAIL midframe_tx_done: got %0d expected 0", done_cnt - base_done);
        end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL held_flag_no_edge: busy=%b expected 0", busy); end
        @(negedge CLOCK_50);
        send_flag = 1'b0;
        exp_q.push_back(8'h3C);
        apply_stimulus(8'h3C, d);
        wait_idle(FRAME_BITS * C + 100, "after_reset");
        vectors++;
        if (rx_count - base_rx != 1) begin
            miscompares++; $display("[TB] FAIL after_reset_frames: got %0d expected 1", rx_count - base_rx);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        int spacing;
        start_q.delete();
        exp_q.push_back(8'h00);
        apply_stimulus(8'h00, d);
        exp_q.push_back(8'hFF);
        apply_stimulus(8'hFF, d);
        wait_idle(2 * (FRAME_BITS * C + 1) + 200, "back_to_back");
        spacing = (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1;
        vectors += 2;
        if (start_q.size() != 2) begin
            miscompares++; $display("[TB] FAIL b2b_frames: got %0d expected 2", start_q.size());
        end
        if (spacing != FRAME_BITS * C + 1) begin
            miscompares++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", spacing, FRAME_BITS * C + 1);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int d;
        int base_rx = rx_count;
        exp_q.push_back(8'h07);
        apply_stimulus(8'h07, d);
        exp_q.push_back(8'h03);
        apply_stimulus(8'h03, d);
        wait_idle(2 * (FRAME_BITS * C + 1) + 200, "parity");
        vectors++;
        if (rx_count - base_rx != 2) begin
            miscompares++; $display("[TB] FAIL parity_frames: got %0d expected 2", rx_count - base_rx);
        end
    endtask
`endif

    initial begin
        reset_n   = 1'b1;
        send_flag = 1'b0;
        in        = 8'h00;
        test_reset();
        test_single();
        test_overflow();
        test_reset();
        test_hold();
        test_reset_midframe();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("[TB] FAIL final_pending: got %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 4, power of two: transmit queue depth in bytes.
REQ-004 CLOCK_50  input  1  sole clock; all state on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in  input  8  byte to transmit; sampled on the cycle send_flag's rising edge is detected.
REQ-007 send_flag  input  1  level request; each 0->1 transition queues exactly one byte.
REQ-008 UART_TX  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 fifo_full  output  1  high when FIFO holds FIFO_DEPTH bytes.
REQ-011 tx_done  output  1  one-cycle pulse at end of each stop bit.
REQ-012 overflow  output  1  sticky; set when a request is dropped because the FIFO is full.

Function
REQ-013 Edge detector: registered copy of send_flag; push = send_flag & ~prev; one push per rising edge regardless of how long send_flag stays high.
REQ-014 Push when FIFO not full writes in at write pointer; pointers wrap modulo FIFO_DEPTH; occupancy count 0..FIFO_DEPTH.
REQ-015 Push while fifo_full: byte discarded, FIFO unchanged, overflow set next cycle.
REQ-016 Push and pop in the same cycle: both performed, count unchanged; when full, push judged against full before the pop, so it is dropped.
REQ-017 FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-018 IDLE: UART_TX=1; if FIFO non-empty, pop head into shift register and enter START next cycle.
REQ-019 START: UART_TX=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles; 3-bit index counts 0..7, then PARITY or STOP.
REQ-021 STOP: UART_TX=1 for exactly CLKS_PER_BIT cycles; tx_done pulses in the last STOP cycle; then IDLE.
REQ-022 Minimum one IDLE cycle between frames; back-to-back frame period = 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
REQ-023 Latency: push in cycle N into empty idle FIFO -> UART_TX falls at cycle N+2.
REQ-024 Baud counter counts 0..CLKS_PER_BIT-1, clears on every state change; width = clog2(CLKS_PER_BIT).
REQ-025 in and send_flag changes during a frame do not affect the frame in flight.

Reset
REQ-026 reset_n low asynchronously forces: UART_TX=1, state IDLE, FIFO empty (pointers, count=0), busy=0, fifo_full=0, tx_done=0, overflow=0, edge register=0.
REQ-027 Reset mid-frame aborts the frame immediately; queued bytes are lost; no tx_done.
REQ-028 After reset_n deasserts, send_flag already high does not count as a rising edge until it goes low then high.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA, transmits even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles.
REQ-030 Macro undefined: no PARITY state, no parity logic; frame is 8N1.

Verification
REQ-031 Reset, send_flag pulse with in=0x55 -> UART_TX falls 2 cycles after edge; line bits 0,1,0,1,0,1,0,1,0,1 each 434 cycles; tx_done once; busy low afterwards.
REQ-032 Five pushes 0x01..0x05 in consecutive edges while first frame active -> 0x01..0x04 transmitted in order, 0x05 dropped, overflow=1, fifo_full seen high.
REQ-033 send_flag held high 10000 cycles with in=0xA3 -> exactly one frame of 0xA3.
REQ-034 reset_n pulsed low during DATA bit 3 of 0xFF with 2 bytes queued -> UART_TX=1 same cycle, no further frames, all outputs at reset values.
REQ-035 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 11*434 cycles; send 0x03 -> parity bit 0.
REQ-036 Back-to-back 0x00,0xFF queued -> start edges of consecutive frames 4341 cycles apart.
